// File: rtl/vtx_fixed_assembler.sv
// vtx_fixed_assembler: converts a stream of nine IEEE-754 singles (Ax..Cz) to fixed point and presents one triangle
// Ports:
//   clock, reset_n          clock, asynchronous active-low reset
//   in_float/in_valid/in_ready/in_abort   float word stream; abort drops the partial triangle
//   tri_x/tri_y/tri_z       {C,B,A} fixed-point coordinates, 32 bits each
//   tri_degen               two vertices share X and Y
//   tri_valid/tri_ready     triangle handshake
//   tri_ovf                 only with VTX_FIXED_SAT_EN: some word of this triangle saturated
// Optional feature macro: VTX_FIXED_SAT_EN (saturate instead of wrap, adds tri_ovf)
module vtx_fixed_assembler #(
    parameter int XY_FRAC = 4,
    parameter int Z_FRAC  = 16
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [31:0] in_float,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_abort,
    output logic [95:0] tri_x,
    output logic [95:0] tri_y,
    output logic [95:0] tri_z,
    output logic        tri_degen,
    output logic        tri_valid,
    input  logic        tri_ready
`ifdef VTX_FIXED_SAT_EN
    ,
    output logic        tri_ovf
`endif
);
    typedef enum logic {COLLECT, PRESENT} state_t;
    state_t state;
    logic [3:0] cnt;
    logic [1:0] comp, vert;
    logic [2:0][31:0] sx, sy;
    logic [1:0][31:0] sz;
    logic [7:0] exp_f;
    logic [63:0] m;
    logic [5:0] amt;
    logic [30:0] mag;
    logic [31:0] conv;
    int sh;
`ifdef VTX_FIXED_SAT_EN
    logic big, ovf_acc;
`endif
    assign in_ready  = state == COLLECT;
    assign tri_valid = state == PRESENT;
    assign comp = 2'(cnt % 4'd3);
    assign vert = 2'(cnt / 4'd3);
    // Shift amount is clamped so a 64-bit intermediate always yields the correct low 31 bits.
    always_comb begin
        exp_f = in_float[30:23];
        m     = {40'd0, 1'b1, in_float[22:0]};
        sh    = int'(exp_f) - 150 + (comp == 2'd2 ? Z_FRAC : XY_FRAC);
        amt   = (sh > 63 || sh < -63) ? 6'd63 : sh < 0 ? 6'(-sh) : 6'(sh);
        mag   = sh < 0 ? 31'(m >> amt) : 31'(m << amt);
`ifdef VTX_FIXED_SAT_EN
        // M >= 2^23, so any left shift of 8 or more reaches 2^31.
        big   = exp_f != 8'd0 && sh >= 8;
        conv  = exp_f == 8'd0 ? 32'd0 :
                big ? (in_float[31] ? 32'h8000_0000 : 32'h7FFF_FFFF) :
                {in_float[31], in_float[31] ? ~mag : mag};
`else
        conv  = exp_f == 8'd0 ? 32'd0 : {in_float[31], in_float[31] ? ~mag : mag};
`endif
    end
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= COLLECT;
            cnt       <= 4'd0;
            sx        <= '0;
            sy        <= '0;
            sz        <= '0;
            tri_x     <= '0;
            tri_y     <= '0;
            tri_z     <= '0;
            tri_degen <= 1'b0;
`ifdef VTX_FIXED_SAT_EN
            ovf_acc   <= 1'b0;
            tri_ovf   <= 1'b0;
`endif
        end else if (state == PRESENT) begin
            if (tri_ready)
                state <= COLLECT;
        end else if (in_abort) begin
            cnt <= 4'd0;
        end else if (in_valid) begin
            if (comp == 2'd0)
                sx[vert] <= conv;
            else if (comp == 2'd1)
                sy[vert] <= conv;
            else if (vert != 2'd2)
                sz[vert[0]] <= conv;
            cnt <= cnt == 4'd8 ? 4'd0 : cnt + 4'd1;
            // Word 8 is Cz, so all X/Y slots are already final for the degenerate test.
            if (cnt == 4'd8) begin
                state     <= PRESENT;
                tri_x     <= sx;
                tri_y     <= sy;
                tri_z     <= {conv, sz};
                tri_degen <= (sx[0] == sx[1] && sy[0] == sy[1]) ||
                             (sx[1] == sx[2] && sy[1] == sy[2]) ||
                             (sx[0] == sx[2] && sy[0] == sy[2]);
            end
`ifdef VTX_FIXED_SAT_EN
            ovf_acc <= cnt == 4'd0 ? big : ovf_acc | big;
            if (cnt == 4'd0)
                tri_ovf <= 1'b0;
            if (cnt == 4'd8)
                tri_ovf <= ovf_acc | big;
`endif
        end
    end
endmodule

// File: tb/tb_vtx_fixed_assembler.sv
// tb_vtx_fixed_assembler: directed scoreboard bench for vtx_fixed_assembler
module tb_vtx_fixed_assembler;
    logic clock = 1'b0;
    logic reset_n;
    logic [31:0] in_float;
    logic in_valid, in_ready, in_abort;
    logic [95:0] tri_x, tri_y, tri_z;
    logic tri_degen, tri_valid, tri_ready;
`ifdef VTX_FIXED_SAT_EN
    logic tri_ovf;
`endif
    typedef struct {
        logic [95:0] x, y, z;
        logic degen, ovf;
    } tri_t;
    tri_t sb[$];
    int n_chk = 0, n_pass = 0, n_fail = 0;
    logic [31:0] w[9];

    vtx_fixed_assembler #(.XY_FRAC(4), .Z_FRAC(16)) dut (
        .clock(clock), .reset_n(reset_n), .in_float(in_float), .in_valid(in_valid),
        .in_ready(in_ready), .in_abort(in_abort), .tri_x(tri_x), .tri_y(tri_y),
        .tri_z(tri_z), .tri_degen(tri_degen), .tri_valid(tri_valid), .tri_ready(tri_ready)
`ifdef VTX_FIXED_SAT_EN
        , .tri_ovf(tri_ovf)
`endif
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference conversion through real arithmetic: value * 2^frac, truncated, wrapped modulo 2^31.
    function automatic logic [31:0] model(input logic [31:0] f, input int frac, output logic sat);
        real v, lim;
        logic [30:0] mg;
        lim = 2147483648.0;
        sat = 1'b0;
        if (f[30:23] == 8'd0) return 32'd0;
        v = (1.0 + real'(f[22:0]) / 8388608.0) * (2.0 ** real'(int'(f[30:23]) - 127 + frac));
        sat = v >= lim;
        v = v - lim * $floor(v / lim);
        mg = 31'($rtoi(v));
`ifdef VTX_FIXED_SAT_EN
        if (sat) return f[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
`endif
        return {f[31], f[31] ? ~mg : mg};
    endfunction

    task automatic send_tri(input logic [31:0] wv[9]);
        tri_t e;
        logic [31:0] c[9];
        logic s;
        e.ovf = 1'b0;
        for (int i = 0; i < 9; i++) begin
            c[i] = model(wv[i], (i % 3 == 2) ? 16 : 4, s);
            e.ovf = e.ovf | s;
        end
        e.x = {c[6], c[3], c[0]};
        e.y = {c[7], c[4], c[1]};
        e.z = {c[8], c[5], c[2]};
        e.degen = (c[0] == c[3] && c[1] == c[4]) || (c[3] == c[6] && c[4] == c[7]) ||
                  (c[0] == c[6] && c[1] == c[7]);
        sb.push_back(e);
        for (int i = 0; i < 9; i++) begin
            in_float = wv[i];
            in_valid = 1'b1;
            if (i == 8) begin
                @(negedge clock);
                check("pre_last_valid", tri_valid, 0);
                check("pre_last_ready", in_ready, 1);
            end
            @(posedge clock);
            #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        for (int k = 0; k < 20 && sb.size() != 0; k++) @(posedge clock);
        #1;
        check("drain_timeout", sb.size(), 0);
    endtask

    task automatic finish_tri(input string tag);
        @(negedge clock);
        check({tag, "_valid"}, tri_valid, 1);
        check({tag, "_in_ready_low"}, in_ready, 0);
        @(posedge clock);
        #1;
        wait_drain();
    endtask

    always @(negedge clock) begin
        if (reset_n && tri_valid && tri_ready) begin
            check("tri_expected", sb.size() != 0, 1);
            if (sb.size() != 0) begin
                tri_t e;
                e = sb.pop_front();
                check("tri_x", tri_x, e.x);
                check("tri_y", tri_y, e.y);
                check("tri_z", tri_z, e.z);
                check("tri_degen", tri_degen, e.degen);
`ifdef VTX_FIXED_SAT_EN
                check("tri_ovf", tri_ovf, e.ovf);
`endif
            end
        end
    end

    initial begin
        #200000;
        $error("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0; in_valid = 1'b0; in_abort = 1'b0; in_float = 32'd0; tri_ready = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;
        @(negedge clock);
        check("rst_in_ready", in_ready, 1);
        check("rst_tri_valid", tri_valid, 0);
        check("rst_tri_x", tri_x, 0);
        check("rst_tri_y", tri_y, 0);
        check("rst_tri_z", tri_z, 0);
        check("rst_degen", tri_degen, 0);
        @(posedge clock);
        #1;
        // Basic triangle, immediate handshake
        w = '{32'h3F800000, 32'hC0200000, 32'h3F000000, 32'h40000000, 32'h40000000,
              32'h40000000, 32'h40000000, 32'h40000000, 32'h40000000};
        send_tri(w);
        @(negedge clock);
        check("t1_valid", tri_valid, 1);
        check("t1_in_ready_low", in_ready, 0);
        check("t1_ax", tri_x[31:0], 32'h00000010);
        check("t1_ay", tri_y[31:0], 32'hFFFFFFD7);
        check("t1_az", tri_z[31:0], 32'h00008000);
        @(negedge clock);
        check("t1_valid_fall", tri_valid, 0);
        check("t1_in_ready_back", in_ready, 1);
        check("t1_data_hold", tri_x[31:0], 32'h00000010);
        @(posedge clock);
        #1;
        wait_drain();
        // Stalled handshake with in_valid held high
        tri_ready = 1'b0;
        send_tri(w);
        in_valid = 1'b1;
        in_float = 32'h41200000;
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            check("stall_valid", tri_valid, 1);
            check("stall_in_ready", in_ready, 0);
            check("stall_x", tri_x, sb[0].x);
            check("stall_y", tri_y, sb[0].y);
            @(posedge clock);
            #1;
        end
        tri_ready = 1'b1;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        @(negedge clock);
        check("stall_release_ready", in_ready, 1);
        check("stall_release_valid", tri_valid, 0);
        @(posedge clock);
        #1;
        wait_drain();
        // Abort after four words; abort-cycle word dropped
        for (int i = 0; i < 4; i++) begin
            in_float = 32'h41000000 + 32'(i);
            in_valid = 1'b1;
            @(posedge clock);
            #1;
        end
        in_abort = 1'b1;
        in_float = 32'h42000000;
        @(posedge clock);
        #1;
        in_abort = 1'b0;
        in_valid = 1'b0;
        w = '{32'h40A00000, 32'h40400000, 32'h3E800000, 32'h3F800000, 32'hBF800000,
              32'h40400000, 32'hC0000000, 32'h40800000, 32'hC1000000};
        send_tri(w);
        @(negedge clock);
        check("abort_ax", tri_x[31:0], 32'h00000050);
        @(posedge clock);
        #1;
        wait_drain();
        // Overflow, denormal, negative truncation, exp=255
        w = '{32'h3F800000, 32'h3F800000, 32'h3F800000, 32'hC0700000, 32'hBD000000,
              32'h7F800000, 32'h4F800000, 32'h00000001, 32'h3F800000};
        send_tri(w);
        @(negedge clock);
`ifdef VTX_FIXED_SAT_EN
        check("ovf_cx", tri_x[95:64], 32'h7FFFFFFF);
        check("ovf_flag", tri_ovf, 1);
`else
        check("ovf_cx", tri_x[95:64], 32'h00000000);
`endif
        check("denorm_cy", tri_y[95:64], 32'h00000000);
        check("neg_bx", tri_x[63:32], 32'hFFFFFFC3);
        @(posedge clock);
        #1;
        wait_drain();
        // Degenerate: A and C coincide
        w = '{32'h41200000, 32'h41200000, 32'h3F800000, 32'h40000000, 32'h40000000,
              32'h3F800000, 32'h41200000, 32'h41200000, 32'h40000000};
        send_tri(w);
        @(negedge clock);
        check("degen_ac", tri_degen, 1);
        @(posedge clock);
        #1;
        wait_drain();
        // All distinct
        w = '{32'h41200000, 32'h41200000, 32'h3F800000, 32'h40000000, 32'h40000000,
              32'h3F800000, 32'h40400000, 32'h40800000, 32'h40000000};
        send_tri(w);
        @(negedge clock);
        check("degen_distinct", tri_degen, 0);
        @(posedge clock);
        #1;
        wait_drain();
        // Same X on A and B, different Y
        w = '{32'h41200000, 32'h41200000, 32'h3F800000, 32'h41200000, 32'h40000000,
              32'h3F800000, 32'h40400000, 32'h40800000, 32'h40000000};
        send_tri(w);
        @(negedge clock);
        check("degen_x_only", tri_degen, 0);
        @(posedge clock);
        #1;
        wait_drain();
        // Asynchronous reset after six words
        for (int i = 0; i < 6; i++) begin
            in_float = 32'h40E00000;
            in_valid = 1'b1;
            @(posedge clock);
            #1;
        end
        in_valid = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_tri_x", tri_x, 0);
        check("arst_tri_y", tri_y, 0);
        check("arst_tri_z", tri_z, 0);
        check("arst_valid", tri_valid, 0);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        w = '{32'h3F800000, 32'hC0200000, 32'h3F000000, 32'h40000000, 32'h40400000,
              32'h40800000, 32'h40A00000, 32'h40C00000, 32'h40E00000};
        send_tri(w);
        finish_tri("post_rst");
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/vtx_fixed_assembler.md
Name: vtx_fixed_assembler

Overview:
- Sits between the ISP parameter-word reader and triangle setup in the PVR pipeline.
- Accepts a stream of 32-bit IEEE-754 single floats: vertex A, B, C, each as X, Y, Z.
- Converts each word to signed fixed point as it arrives, using sign-magnitude semantics with inverted magnitude bits for negatives.
- Buffers the nine results and presents one complete triangle to setup over a valid/ready handshake, with a degenerate-triangle flag.

Parameters:
- XY_FRAC, 4: fraction bits for X and Y results (0..23).
- Z_FRAC, 16: fraction bits for Z results (0..23).

Ports:
- clock  in  1  system clock; all state updates on its rising edge.
- reset_n  in  1  asynchronous active-low reset.
- in_float  in  32  float word: sign [31], exponent [30:23], mantissa [22:0].
- in_valid  in  1  in_float is valid.
- in_ready  out  1  block accepts a word this cycle.
- in_abort  in  1  discard the partially collected triangle.
- tri_x  out  96  fixed X: {C,B,A}, 32 bits each, A in [31:0].
- tri_y  out  96  fixed Y, same packing as tri_x.
- tri_z  out  96  fixed Z, same packing as tri_x.
- tri_degen  out  1  any two vertices have identical X and identical Y.
- tri_valid  out  1  triangle bundle valid.
- tri_ready  in  1  setup consumes the bundle.

Behaviour:
- Clock and reset: one clock, `clock`. `reset_n` is asynchronous and active-low.
- Reset values:
  - state=COLLECT, word counter=0.
  - tri_x, tri_y, tri_z, tri_degen, tri_valid all 0.
  - in_ready=1 once reset is released.
- Reset mid-operation discards all collected words with no output.
- States:
  - COLLECT: in_ready=1, tri_valid=0.
  - PRESENT: in_ready=0, tri_valid=1.
- Word acceptance and ordering:
  - A word is accepted on a cycle with in_valid & in_ready.
  - Counter 0..8 maps to Ax, Ay, Az, Bx, By, Bz, Cx, Cy, Cz.
  - Each accepted word is converted combinationally and written into its slot register in the same edge.
- Transition to PRESENT:
  - On acceptance of word 8, counter returns to 0 and state becomes PRESENT.
  - tri_valid rises the cycle after the 9th word is accepted (1-cycle latency).
  - tri_degen is registered at the same edge from the final slot values: (A==B) | (B==C) | (A==C), where equality compares X and Y only.
- PRESENT:
  - Bundle and flag are held stable while tri_ready=0.
  - On tri_valid & tri_ready, state becomes COLLECT next cycle. tri_valid falls; output data retain old values.
  - No word is accepted on the handshake cycle.
- in_abort:
  - In COLLECT, forces counter=0 and takes priority over a same-cycle accept; that word is dropped.
  - In PRESENT, in_abort is ignored.
- Conversion, per word, with F = XY_FRAC or Z_FRAC by slot:
  - exp==0 (zero/denormal): result 0x00000000 regardless of sign.
  - Otherwise: M = {1, mantissa} (24 bits), s = exp - 127 + F - 23.
  - Magnitude: mag = M << s if s >= 0, else M >> -s (truncation toward zero).
  - mag is computed wide enough (at least 64 bits pre-truncation, shift clamped at 63) that no intermediate bits are lost before selecting [30:0].
  - exp==255 is treated as an ordinary exponent; no NaN/Inf handling.
  - Output: sign=0 -> {0, mag[30:0]}; sign=1 -> {1, ~mag[30:0]}.
  - Overflow (mag >= 2^31): bits above [30] are discarded, so the result wraps.

Optional Feature:
- Macro: VTX_FIXED_SAT_EN.
- When defined:
  - mag >= 2^31 clamps positive results to 0x7FFFFFFF and negative results to 0x80000000.
  - Adds a sticky output tri_ovf (1 bit, reset 0): set if any of the nine words saturated; cleared when the next triangle's first word is accepted.
- When undefined:
  - Wrap behaviour as above.
  - tri_ovf port absent.

Test Plan:
- Nine words, Ax=0x3F800000 (1.0), Ay=0xC0200000 (-2.5), Az=0x3F000000 (0.5), others 0x40000000, XY_FRAC=4, Z_FRAC=16, tri_ready=1 -> A fields are 0x00000010, 0xFFFFFFD7, 0x00008000; tri_valid high exactly one cycle after the 9th accept; in_ready low that cycle.
- Same triangle with tri_ready=0 for 5 cycles -> bundle stable, in_ready=0, in_valid words not consumed; handshake on cycle 6 -> in_ready=1 next cycle.
- in_abort asserted with in_valid after 4 words -> abort-cycle word dropped; the next 9 words form the triangle (verify slot A matches the first of the new words).
- A and C both X=0x41200000, Y=0x41200000, B different -> tri_degen=1; all distinct -> 0; A.X==B.X with A.Y!=B.Y -> 0.
- Cx=0x4F800000 (2^32), XY_FRAC=4 -> 0x00000000 without macro; 0x7FFFFFFF and tri_ovf=1 with VTX_FIXED_SAT_EN. Cy=0x00000001 (denormal) -> 0x00000000.
- reset_n pulsed low asynchronously after word 6 -> outputs zero immediately; a full subsequent triangle is assembled correctly from word 0.
